// File: rtl/loop_replay_buffer_pkg.sv
// Shared types and constants for the loop replay buffer.
// Optional feature macro used by the top: LOOP_STATS_EN (replay iteration counter).
package loop_buf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        REPLAY,
        FLUSH
    } lrb_state_t;

    // RISC-V conditional branch major opcode (B-type)
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/loop_replay_buffer_if.sv
// Fetch/decode-side bus of the loop replay buffer.
// master: the fetch/resolve side driving instructions and mispredicts.
// slave : the loop replay buffer itself.
interface loop_replay_buffer_if #(
    parameter int XLEN = 32
);
    logic            instr_valid;
    logic [XLEN-1:0] curr_PC;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] immediate;
    logic            mispredict;
    logic            block_signal;
    logic            flush;
    logic [XLEN-1:0] new_pc;
    logic            out_valid;
    logic [XLEN-1:0] out_instruction;
    logic [XLEN-1:0] out_pc;

    modport master (
        output instr_valid, curr_PC, instruction, immediate, mispredict,
        input  block_signal, flush, new_pc, out_valid, out_instruction, out_pc
    );

    modport slave (
        input  instr_valid, curr_PC, instruction, immediate, mispredict,
        output block_signal, flush, new_pc, out_valid, out_instruction, out_pc
    );
endinterface

// File: rtl/loop_replay_buffer_mem.sv
// Loop body storage: DEPTH x XLEN registers, synchronous write, asynchronous read.
// Contents are not reset; only entries written during capture are ever read.
module loop_buf_mem #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [XLEN-1:0]  wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [XLEN-1:0]  rdata
);
    logic [XLEN-1:0] mem [DEPTH];

    // Capture write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/loop_replay_buffer.sv
// Loop replay buffer between fetch and decode: captures a short backward-branch
// loop body and replays it while stalling fetch; flushes to the fall-through PC
// on a loop-exit mispredict.
// Optional macro LOOP_STATS_EN adds the iter_count output (completed replay laps).
module loop_replay_buffer
    import loop_buf_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    loop_replay_buffer_if.slave   bus
`ifdef LOOP_STATS_EN
    ,
    output logic [15:0]           iter_count
`endif
);
    localparam int PTR_W = $clog2(DEPTH);

    lrb_state_t      state;
    logic [XLEN-1:0] s_pc;
    logic [XLEN-1:0] e_pc;
    logic [PTR_W-1:0] last_idx;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [XLEN-1:0] neg_imm;
    logic [XLEN-1:0] body_idx;
    logic [XLEN-1:0] wr_pc;
    logic [XLEN-1:0] rd_pc;
    logic [XLEN-1:0] rd_data;
    logic            is_bbr;
    logic            fits;
    logic            wr_match;
    logic            mem_we;
    logic            wrap;

    // Branch decode, body-length check and PC arithmetic for both pointers
    always_comb begin
        neg_imm  = -bus.immediate;
        body_idx = neg_imm >> 2;
        is_bbr   = bus.instr_valid && (bus.instruction[6:0] == OPC_BRANCH)
                   && bus.immediate[XLEN-1];
        fits     = body_idx < XLEN'(DEPTH);
        wr_pc    = s_pc + XLEN'({wr_ptr, 2'b00});
        rd_pc    = s_pc + XLEN'({rd_ptr, 2'b00});
        wr_match = bus.instr_valid && (bus.curr_PC == wr_pc);
        mem_we   = (state == CAPTURE) && !bus.mispredict && wr_match;
        wrap     = (rd_ptr == last_idx);
    end

    loop_buf_mem #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (bus.instruction),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            s_pc                <= '0;
            e_pc                <= '0;
            last_idx            <= '0;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            bus.block_signal    <= 1'b0;
            bus.flush           <= 1'b0;
            bus.new_pc          <= '0;
            bus.out_valid       <= 1'b0;
            bus.out_instruction <= '0;
            bus.out_pc          <= '0;
`ifdef LOOP_STATS_EN
            iter_count          <= '0;
`endif
        end else begin
            bus.flush  <= 1'b0;
            bus.new_pc <= '0;
            case (state)
                IDLE, CAPTURE: begin
                    bus.block_signal <= 1'b0;
                    bus.out_valid    <= bus.instr_valid;
                    if (bus.instr_valid) begin
                        bus.out_instruction <= bus.instruction;
                        bus.out_pc          <= bus.curr_PC;
                    end
                    if (state == IDLE) begin
                        if (is_bbr && fits) begin
                            s_pc     <= bus.curr_PC + bus.immediate;
                            e_pc     <= bus.curr_PC;
                            last_idx <= body_idx[PTR_W-1:0];
                            wr_ptr   <= '0;
                            state    <= CAPTURE;
                        end
                    end else if (bus.mispredict) begin
                        state <= IDLE;
                    end else if (bus.instr_valid) begin
                        if (!wr_match) begin
                            state <= IDLE;
                        end else if ((bus.curr_PC == e_pc) && (wr_ptr == last_idx)) begin
                            state            <= REPLAY;
                            rd_ptr           <= '0;
                            bus.block_signal <= 1'b1;
`ifdef LOOP_STATS_EN
                            iter_count       <= '0;
`endif
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                REPLAY: begin
                    // Mispredict takes priority over a same-cycle wrap
                    if (bus.mispredict) begin
                        state            <= FLUSH;
                        bus.flush        <= 1'b1;
                        bus.new_pc       <= e_pc + XLEN'(4);
                        bus.block_signal <= 1'b0;
                        bus.out_valid    <= 1'b0;
                    end else begin
                        bus.out_valid       <= 1'b1;
                        bus.out_instruction <= rd_data;
                        bus.out_pc          <= rd_pc;
                        rd_ptr              <= wrap ? '0 : rd_ptr + 1'b1;
`ifdef LOOP_STATS_EN
                        if (wrap && (iter_count != 16'hFFFF)) begin
                            iter_count <= iter_count + 16'd1;
                        end
`endif
                    end
                end
                FLUSH: begin
                    bus.out_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_loop_replay_buffer.sv
// Directed self-checking bench for loop_replay_buffer (XLEN=32, DEPTH=16).
// Honours LOOP_STATS_EN when defined.
module tb_loop_replay_buffer;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BR   = 32'hFE00_0EE3;
    localparam logic [31:0] IM12 = 32'hFFFF_FFF4;  // -12
    localparam logic [31:0] IM60 = 32'hFFFF_FFC4;  // -60 -> N = 16
    localparam logic [31:0] IM64 = 32'hFFFF_FFC0;  // -64 -> N = 17

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
`ifdef LOOP_STATS_EN
    logic [15:0] iter_count;
`endif

    loop_replay_buffer_if #(.XLEN(32)) bus ();

    loop_replay_buffer #(
        .XLEN  (32),
        .DEPTH (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef LOOP_STATS_EN
        ,
        .iter_count (iter_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] imm, input logic exp_blk);
        bus.instr_valid = 1'b1;
        bus.curr_PC     = pc;
        bus.instruction = ins;
        bus.immediate   = imm;
        step();
        chk("pt_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("pt_pc", bus.out_pc, pc);
        chk("pt_instr", bus.out_instruction, ins);
        chk("pt_block", {31'b0, bus.block_signal}, {31'b0, exp_blk});
        chk("pt_flush", {31'b0, bus.flush}, 32'd0);
    endtask

    task automatic chk_replay(input logic [31:0] pc, input logic [31:0] ins);
        chk("rp_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("rp_pc", bus.out_pc, pc);
        chk("rp_instr", bus.out_instruction, ins);
        chk("rp_block", {31'b0, bus.block_signal}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_block"}, {31'b0, bus.block_signal}, 32'd0);
        chk({tag, "_flush"}, {31'b0, bus.flush}, 32'd0);
        chk({tag, "_newpc"}, bus.new_pc, 32'd0);
        chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd0);
        chk({tag, "_instr"}, bus.out_instruction, 32'd0);
        chk({tag, "_pc"}, bus.out_pc, 32'd0);
`ifdef LOOP_STATS_EN
        chk({tag, "_iter"}, {16'h0, iter_count}, 32'd0);
`endif
    endtask

    initial begin
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.curr_PC     = '0;
        bus.instruction = '0;
        bus.immediate   = '0;
        bus.mispredict  = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        reset = 1'b0;

        // 4-instruction loop: first pass arms CAPTURE, second pass enters REPLAY
        feed(32'h100, NOP, 32'h0, 1'b0);
        feed(32'h104, NOP, 32'h0, 1'b0);
        feed(32'h108, NOP, 32'h0, 1'b0);
        feed(32'h10C, BR,  IM12,  1'b0);
        feed(32'h100, NOP, 32'h0, 1'b0);
        feed(32'h104, NOP, 32'h0, 1'b0);
        feed(32'h108, NOP, 32'h0, 1'b0);
        feed(32'h10C, BR,  IM12,  1'b1);

        // Inputs must be ignored while replaying
        bus.curr_PC     = 32'h500;
        bus.instruction = BR;
        bus.immediate   = IM12;
        for (int lap = 1; lap <= 5; lap++) begin
            for (int i = 0; i < 4; i++) begin
                step();
                chk_replay(32'h100 + 32'(4 * i), (i == 3) ? BR : NOP);
`ifdef LOOP_STATS_EN
                if (i == 3) chk("iter_lap", {16'h0, iter_count}, 32'(lap));
`endif
            end
        end

        // Loop exit
        bus.mispredict  = 1'b1;
        bus.instr_valid = 1'b0;
        step();
        bus.mispredict = 1'b0;
        chk("mp_flush", {31'b0, bus.flush}, 32'd1);
        chk("mp_newpc", bus.new_pc, 32'h110);
        chk("mp_block", {31'b0, bus.block_signal}, 32'd0);
        chk("mp_valid", {31'b0, bus.out_valid}, 32'd0);
`ifdef LOOP_STATS_EN
        chk("mp_iter", {16'h0, iter_count}, 32'd5);
`endif
        step();
        chk("post_flush", {31'b0, bus.flush}, 32'd0);
        chk("post_valid", {31'b0, bus.out_valid}, 32'd0);
        feed(32'h110, NOP, 32'h0, 1'b0);
`ifdef LOOP_STATS_EN
        chk("iter_hold", {16'h0, iter_count}, 32'd5);
`endif

        // N = DEPTH+1: branch ignored, no capture on either pass
        for (int i = 0; i < 16; i++) feed(32'h2C0 + 32'(4 * i), NOP, 32'h0, 1'b0);
        feed(32'h300, BR, IM64, 1'b0);
        for (int i = 0; i < 16; i++) feed(32'h2C0 + 32'(4 * i), NOP, 32'h0, 1'b0);
        feed(32'h300, BR, IM64, 1'b0);
        bus.instr_valid = 1'b0;
        step();
        chk("big_block", {31'b0, bus.block_signal}, 32'd0);
        chk("big_valid", {31'b0, bus.out_valid}, 32'd0);

        // N = DEPTH: largest accepted body
        for (int i = 0; i < 15; i++) feed(32'h400 + 32'(4 * i), 32'h1000_0000 + 32'(i), 32'h0, 1'b0);
        feed(32'h43C, BR, IM60, 1'b0);
        for (int i = 0; i < 15; i++) feed(32'h400 + 32'(4 * i), 32'h1000_0000 + 32'(i), 32'h0, 1'b0);
        feed(32'h43C, BR, IM60, 1'b1);
`ifdef LOOP_STATS_EN
        chk("iter_clear", {16'h0, iter_count}, 32'd0);
`endif
        bus.instr_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk_replay(32'h400 + 32'(4 * i), (i == 15) ? BR : 32'h1000_0000 + 32'(i));
        end
        step();
        chk_replay(32'h400, 32'h1000_0000);
`ifdef LOOP_STATS_EN
        chk("iter_full", {16'h0, iter_count}, 32'd1);
`endif

        // Reset while replaying
        reset = 1'b1;
        step();
        chk_all_zero("midrst");
        reset = 1'b0;
        step();
        chk("rst_idle_block", {31'b0, bus.block_signal}, 32'd0);

        // Off-sequence PC aborts capture without flush and is passed through
        feed(32'h10C, BR,  IM12,  1'b0);
        feed(32'h100, NOP, 32'h0, 1'b0);
        feed(32'h200, NOP, 32'h0, 1'b0);
        feed(32'h104, NOP, 32'h0, 1'b0);
        feed(32'h108, NOP, 32'h0, 1'b0);
        feed(32'h10C, NOP, 32'h0, 1'b0);

        // Mispredict during capture aborts to IDLE
        feed(32'h10C, BR, IM12, 1'b0);
        bus.mispredict = 1'b1;
        feed(32'h100, NOP, 32'h0, 1'b0);
        bus.mispredict = 1'b0;
        feed(32'h104, NOP, 32'h0, 1'b0);
        feed(32'h108, NOP, 32'h0, 1'b0);
        feed(32'h10C, NOP, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
